// File: rtl/kernel_host.sv
// kernel_host: initiator side of a synthesized kernel's load/start/done
// interface. Gathers N_ARGS operands from a valid/ready stream, loads them
// onto the kernel's parallel init buses, starts the kernel, and returns the
// result on a valid/ready stream.
//
// Optional feature macro: KERNEL_HOST_TIMEOUT_EN
//   Defined   -> RUN watchdog. After TIMEOUT_CYCLES RUN cycles without
//                k_w_enable, the host emits out_data = 0 with out_err = 1.
//   Undefined -> RUN waits indefinitely and out_err is tied 0.
//
// Handshake semantics (both streams): a word transfers on every rising clk
// edge where valid && ready are both high. A producer holds valid and data
// stable until that transfer happens. in_ready and out_valid are registered.
//
// All outputs except k_init and out_err are registered copies of decisions
// taken from the next state. This means k_r_enable, busy, in_ready and
// out_valid always change on the same edge as the state itself.
module kernel_host #(
    parameter int N_ARGS         = 7,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_err,
    output logic                     busy,
    output logic                     k_r_enable,
    output logic [N_ARGS*DATA_W-1:0] k_init,
    input  logic                     k_w_enable,
    input  logic [DATA_W-1:0]        k_result
);

    localparam int CNT_W = $clog2(N_ARGS);
    localparam logic [CNT_W-1:0] LAST_ARG = CNT_W'(N_ARGS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_EMIT    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   arg_q [N_ARGS];
    logic [DATA_W-1:0]   arg_d [N_ARGS];
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                k_r_enable_q, k_r_enable_d;
    logic                in_fire;
    logic                out_fire;

`ifdef KERNEL_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                out_err_q, out_err_d;
`else
    logic                unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Next-state and next-output decisions for the whole job sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arg_d      = arg_q;
        out_data_d = out_data_q;
`ifdef KERNEL_HOST_TIMEOUT_EN
        tmo_d      = tmo_q;
        out_err_d  = out_err_q;
`endif

        case (state_q)
            ST_COLLECT: begin
                if (in_fire) begin
                    arg_d[cnt_q] = in_data;
                    if (cnt_q == LAST_ARG) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // The kernel latches k_init at the end of this cycle.
                state_d = ST_RUN;
`ifdef KERNEL_HOST_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_RUN: begin
                // A completion in the same cycle as the watchdog limit wins.
                if (k_w_enable) begin
                    out_data_d = k_result;
                    state_d    = ST_EMIT;
`ifdef KERNEL_HOST_TIMEOUT_EN
                    out_err_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = ST_EMIT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        in_ready_d   = (state_d == ST_COLLECT);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
        k_r_enable_d = (state_d != ST_RUN);
        out_valid_d  = (state_d == ST_EMIT);
    end

    // State, argument and output registers; reset holds the kernel in load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= '0;
            arg_q        <= '{default: '0};
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            k_r_enable_q <= 1'b1;
`ifdef KERNEL_HOST_TIMEOUT_EN
            tmo_q        <= '0;
            out_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arg_q        <= arg_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            k_r_enable_q <= k_r_enable_d;
`ifdef KERNEL_HOST_TIMEOUT_EN
            tmo_q        <= tmo_d;
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign k_r_enable = k_r_enable_q;

`ifdef KERNEL_HOST_TIMEOUT_EN
    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

    for (genvar g = 0; g < N_ARGS; g++) begin : g_init
        assign k_init[g*DATA_W +: DATA_W] = arg_q[g];
    end

endmodule

// File: tb/tb_kernel_host.sv
// Bench for kernel_host: a seven-argument adder kernel stand-in (latency 8),
// directed jobs, and a per-cycle compare process backed by an expected queue.
module tb_kernel_host;

    localparam int N_ARGS = 7;
    localparam int DATA_W = 64;
    localparam int KW     = N_ARGS * DATA_W;
    localparam int LAT    = 8;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              busy;
    logic              k_r_enable;
    logic [KW-1:0]     k_init;
    logic              k_w_enable = 1'b0;
    logic [DATA_W-1:0] k_result = '0;

    kernel_host #(
        .N_ARGS(N_ARGS), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy),
        .k_r_enable(k_r_enable), .k_init(k_init),
        .k_w_enable(k_w_enable), .k_result(k_result)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Adder kernel stand-in: loads while r_enable is high, finishes LAT
    // cycles after r_enable drops, holds w_enable until the next r_enable.
    bit                hang_mode = 1'b0;
    int                kcnt = 0;
    logic [DATA_W-1:0] kacc = '0;
    logic [DATA_W-1:0] ksum;
    always @(posedge clk) begin
        if (k_r_enable) begin
            ksum = '0;
            for (int i = 0; i < N_ARGS; i++) ksum = ksum + k_init[i*DATA_W +: DATA_W];
            k_w_enable <= 1'b0;
            kcnt       <= 0;
            kacc       <= ksum;
        end else if (!k_w_enable && !hang_mode) begin
            if (kcnt == LAT - 1) begin
                k_w_enable <= 1'b1;
                k_result   <= kacc;
            end else begin
                kcnt <= kcnt + 1;
            end
        end
    end

    // scoreboard: {err, data} per job, in issue order
    logic [DATA_W:0]   exp_q[$];
    logic [KW-1:0]     cur_init = '0;
    logic [DATA_W-1:0] last_out = '0;
    logic [DATA_W-1:0] prev_out = '0;
    logic              last_err = 1'b0;
    int                last_valid_len = 0;

    // compare process, sampled on the falling edge
    logic              prev_valid = 1'b0;
    logic              prev_fire  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_err   = 1'b0;
    logic              prev_ren   = 1'b1;
    int                run_len    = 0;
    int                valid_len  = 0;
    logic [DATA_W:0]   e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_fire  = 1'b0;
            prev_ren   = 1'b1;
            run_len    = 0;
            valid_len  = 0;
        end else begin
            if (prev_valid && !prev_fire) begin
                chk("out_valid_hold", out_valid, 1);
                chk("out_data_hold", out_data, prev_data);
                chk("out_err_hold", out_err, prev_err);
            end
            if (out_valid) begin
                valid_len++;
                chk("in_ready_during_emit", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_result: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e[DATA_W-1:0]);
                        chk("out_err", out_err, e[DATA_W]);
                    end
                    prev_out       = last_out;
                    last_out       = out_data;
                    last_err       = out_err;
                    last_valid_len = valid_len;
                    valid_len      = 0;
                end
            end
            if (!k_r_enable) begin
                run_len++;
                chk("busy_in_run", busy, 1);
                chk("k_init_run", k_init, cur_init);
            end
            if (k_r_enable && !prev_ren) begin
                if (out_valid) chk("run_len", run_len, hang_mode ? TMO : LAT + 1);
                run_len = 0;
            end
            prev_valid = out_valid;
            prev_fire  = out_valid && out_ready;
            prev_data  = out_data;
            prev_err   = out_err;
            prev_ren   = k_r_enable;
        end
    end

    // driver: one operand, returns #1 after the accepting edge
    task automatic send_op(input logic [DATA_W-1:0] d);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 300) begin
                n_checks++;
                $display("FAIL in_ready_wait: got 0 expected 1 within 300 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // driver: one whole job; pushes its expected result first
    task automatic send_job(input logic [DATA_W-1:0] a[N_ARGS], input bit toggle);
        logic [KW-1:0]     init;
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int k = 0; k < N_ARGS; k++) begin
            init[k*DATA_W +: DATA_W] = a[k];
            sum = sum + a[k];
        end
        if (hang_mode) exp_q.push_back({1'b1, {DATA_W{1'b0}}});
        else           exp_q.push_back({1'b0, sum});
        for (int k = 0; k < N_ARGS; k++) begin
            send_op(a[k]);
            if (k < N_ARGS - 1) begin
                chk("busy_collect", busy, 0);
                chk("in_ready_collect", in_ready, 1);
            end else begin
                cur_init = init;
                chk("busy_load", busy, 1);
                chk("in_ready_load", in_ready, 0);
                chk("k_r_enable_load", k_r_enable, 1);
                chk("k_init_load", k_init, init);
            end
            if (toggle) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            g++;
            if (g > 500) begin
                n_checks++;
                $display("FAIL result_wait: got %0d pending expected 0", exp_q.size());
                exp_q.delete();
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] ops_a[N_ARGS];
    logic [DATA_W-1:0] ops_b[N_ARGS];

    initial begin
        for (int k = 0; k < N_ARGS; k++) begin
            ops_a[k] = DATA_W'(k + 1);
            ops_b[k] = DATA_W'(10 * (k + 1));
        end

        // reset state
        #12;
        chk("rst_k_r_enable", k_r_enable, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_k_init", k_init, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic job, out_ready high
        send_job(ops_a, 1'b0);
        wait_idle();
        chk("job1_sum", last_out, 64'd28);
        chk("job1_err", last_err, 0);
        chk("job1_pulse", last_valid_len, 1);

        // in_valid toggling during collection
        send_job(ops_a, 1'b1);
        wait_idle();
        chk("toggle_sum", last_out, 64'd28);

        // output stall for 5 cycles
        out_ready = 1'b0;
        send_job(ops_a, 1'b0);
        begin
            int g = 0;
            while (1) begin
                @(negedge clk);
                if (out_valid) break;
                g++;
                if (g > 200) begin
                    n_checks++;
                    $display("FAIL out_valid_wait: got 0 expected 1 within 200 cycles");
                    break;
                end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        chk("stall_len", last_valid_len, 6);
        chk("stall_sum", last_out, 64'd28);

        // back-to-back jobs
        send_job(ops_a, 1'b0);
        send_job(ops_b, 1'b0);
        wait_idle();
        chk("b2b_first", prev_out, 64'd28);
        chk("b2b_second", last_out, 64'd280);

        // asynchronous reset while RUN
        send_job(ops_a, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_k_r_enable", k_r_enable, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_k_r_enable", k_r_enable, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_job(ops_a, 1'b0);
        wait_idle();
        chk("post_rst_sum", last_out, 64'd28);
        chk("post_rst_err", last_err, 0);

`ifdef KERNEL_HOST_TIMEOUT_EN
        // kernel never completes
        hang_mode = 1'b1;
        send_job(ops_a, 1'b0);
        wait_idle();
        chk("tmo_data", last_out, 64'd0);
        chk("tmo_err", last_err, 1);
        hang_mode = 1'b0;
        send_job(ops_b, 1'b0);
        wait_idle();
        chk("after_tmo_sum", last_out, 64'd280);
        chk("after_tmo_err", last_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kernel_host.md
# kernel_host

Host-side driver for the synthesized kernels' start/finish protocol (`r_enable`, `init_*`, `w_enable`, `result`).
- Collects N_ARGS operands from an upstream valid/ready stream and presents them on the kernel's parallel init buses.
- Launches the kernel, waits for completion and returns the result on a downstream valid/ready stream.
- Sits between the system bus adapter and one kernel instance; it is the initiator counterpart of the kernel's load/start/done interface.

## Interface
- N_ARGS, 7: number of kernel arguments (2..16).
- DATA_W, 64: operand and result width.
- TIMEOUT_CYCLES, 1024: watchdog limit in RUN; used only with KERNEL_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  upstream operand accepted when in_valid && in_ready.
- in_data  in  DATA_W  operand; the k-th accepted word of a job is argument k (a, b, c, …).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  kernel result.
- out_err  out  1  result is a timeout abort; qualified by out_valid.
- busy  out  1  high in LOAD and RUN.
- k_r_enable  out  1  drives the kernel's r_enable.
- k_init  out  N_ARGS*DATA_W  argument k in bits [k*DATA_W +: DATA_W].
- k_w_enable  in  1  kernel done flag; stays high until the next r_enable.
- k_result  in  DATA_W  kernel result, valid while k_w_enable is high.

## Operation
FSM states: COLLECT, LOAD, RUN, EMIT.

Reset (rst_n low, asynchronous):
- State COLLECT, argument counter 0, all argument registers 0.
- k_r_enable 1, out_valid 0, out_data 0, out_err 0, busy 0, in_ready 0.
- Reset mid-job abandons the job; the held-high k_r_enable reloads the kernel.

COLLECT:
- in_ready = 1.
- Each handshake writes in_data into argument[cnt] and increments cnt.
- The handshake with cnt == N_ARGS-1 goes to LOAD and clears cnt.
- in_valid low stalls indefinitely; no partial-job timeout.

LOAD:
- One cycle; in_ready 0, k_r_enable still 1.
- The kernel samples the complete k_init at the end of this cycle.
- Next state RUN.

RUN:
- k_r_enable 0, in_ready 0.
- On the first cycle with k_w_enable == 1: capture k_result into out_data, set out_err 0, go to EMIT.

EMIT:
- out_valid 1, k_r_enable 1; asserting k_r_enable clears the kernel's w_enable.
- out_data and out_err hold stable until out_valid && out_ready.
- On that handshake: out_valid 0 next cycle, state COLLECT.

Rules:
- k_r_enable is a registered output: 1 in every state except RUN.
- k_w_enable is ignored outside RUN.
- in_ready is 0 outside COLLECT; a new job never overlaps result emission.
- k_init is driven directly from the argument registers and is stable from LOAD through RUN.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Last operand handshake at edge t: LOAD during cycle t..t+1, k_r_enable falls at edge t+1.
- Kernel done (k_w_enable first high) seen at edge u: out_valid high from edge u+1.
- Host overhead: 2 cycles from last operand to kernel start, 1 cycle from kernel done to out_valid.
- Throughput: one job per N_ARGS + 2 + kernel latency + 1 + output-stall cycles.
- Zero-bubble output: out_ready already high gives in_ready high the cycle after the out_valid cycle.

## Configuration
- KERNEL_HOST_TIMEOUT_EN defined:
  - A cycle counter clears on entering RUN and increments every RUN cycle.
  - If it reaches TIMEOUT_CYCLES before k_w_enable, go to EMIT with out_data = 0 and out_err = 1.
  - k_w_enable and timeout in the same cycle: k_w_enable wins (normal result, out_err 0).
- Undefined: no counter, RUN waits indefinitely, out_err tied 0, TIMEOUT_CYCLES unused.

## Test plan
- Reset release, then operands 1,2,3,4,5,6,7 with a seven-argument adder kernel model (latency 8) and out_ready = 1 -> out_data = 28, out_err 0, one out_valid pulse; k_r_enable low for exactly the RUN cycles.
- in_valid toggling 1/0 each cycle during collection -> k_init holds 1..7 in order; LOAD entered only after the 7th handshake.
- out_ready held 0 for 5 cycles after result -> out_valid and out_data stable for 6 cycles; in_ready stays 0; next job accepted after the handshake.
- Back-to-back jobs (1..7) then (10,20,30,40,50,60,70) -> outputs 28 then 280; second job's kernel launch sees no stale w_enable.
- rst_n pulsed low during RUN -> k_r_enable 1 and out_valid 0 immediately (asynchronous); a fresh job 1..7 then yields 28.
- With KERNEL_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 16, kernel model never completes -> out_valid after 16 RUN cycles with out_data 0, out_err 1; a following good job returns out_err 0.
